// File: rtl/adc_spi_capture_pkg.sv
// rtl/adc_spi_capture_pkg.sv - shared frame constants, FSM states and code conversion
package adc_spi_capture_pkg;

    localparam int ADC_BITS   = 12;
    localparam int FRAME_BITS = 16;
    localparam int LEAD_ZEROS = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SETUP = 2'd1,
        ST_SHIFT = 2'd2,
        ST_QUIET = 2'd3
    } state_t;

    // Unipolar straight binary to two's complement: subtract mid-scale by flipping the MSB.
    function automatic logic [ADC_BITS-1:0] to_signed_code(input logic [ADC_BITS-1:0] raw);
        return {~raw[ADC_BITS-1], raw[ADC_BITS-2:0]};
    endfunction

endpackage

// File: rtl/adc_spi_capture_if.sv
// rtl/adc_spi_capture_if.sv - ADC serial pins plus captured-sample outputs
interface adc_spi_capture_if #(
    parameter int DATA_W = 24
);
    logic              sdata;
    logic              cs_n;
    logic              sclk;
    logic [DATA_W-1:0] sample;
    logic              sample_valid;
    logic              busy;
    logic              overrun;

    modport master (
        input  sdata,
        output cs_n, sclk, sample, sample_valid, busy, overrun
    );

    modport slave (
        output sdata,
        input  cs_n, sclk, sample, sample_valid, busy, overrun
    );
endinterface

// File: rtl/adc_spi_capture_sample_tick_gen.sv
// rtl/adc_spi_capture_sample_tick_gen.sv - conversion request rate counter
module sample_tick_gen #(
    parameter int SAMPLE_PERIOD = 2000
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    output logic tick
);
    localparam int CW = $clog2(SAMPLE_PERIOD + 1);
    localparam logic [CW-1:0] LAST = CW'(SAMPLE_PERIOD - 1);

    logic [CW-1:0] count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (!en || count == LAST) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

    assign tick = en && (count == LAST);
endmodule

// File: rtl/adc_spi_capture.sv
// rtl/adc_spi_capture.sv - periodic AD7476-style serial ADC reader producing signed Q1.(DATA_W-1) samples
module adc_spi_capture
    import adc_spi_capture_pkg::*;
#(
    parameter int DATA_W        = 24,
    parameter int SCLK_HALF     = 4,
    parameter int SAMPLE_PERIOD = 2000
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               en,
    adc_spi_capture_if.master  adc
);
    localparam int SHIFT_W = FRAME_BITS - LEAD_ZEROS;
    localparam int PW      = $clog2(2 * SCLK_HALF);
    localparam logic [PW-1:0] H_LAST  = PW'(SCLK_HALF - 1);
    localparam logic [PW-1:0] H_COUNT = PW'(SCLK_HALF);
    localparam logic [PW-1:0] P_LAST  = PW'(2 * SCLK_HALF - 1);
    localparam logic [3:0]    BIT_LAST = 4'(FRAME_BITS - 1);

    state_t             state, state_nxt;
    logic [PW-1:0]      ph, ph_nxt;
    logic [3:0]         bit_cnt, bit_nxt;
    logic [SHIFT_W-1:0] shift_q;
    logic               capture, done, tick;

    sample_tick_gen #(.SAMPLE_PERIOD(SAMPLE_PERIOD)) u_tick (
        .clk   (clk),
        .reset (reset),
        .en    (en),
        .tick  (tick)
    );

    always_comb begin
        state_nxt = state;
        ph_nxt    = ph + 1'b1;
        bit_nxt   = bit_cnt;
        capture   = 1'b0;
        done      = 1'b0;
        case (state)
            ST_IDLE: begin
                ph_nxt = '0;
                if (tick) state_nxt = ST_SETUP;
            end
            ST_SETUP: begin
                if (ph == H_LAST) begin
                    state_nxt = ST_SHIFT;
                    ph_nxt    = '0;
                    bit_nxt   = '0;
                end
            end
            ST_SHIFT: begin
                // Sample on the edge that drives sclk back high, mid-bit for the ADC.
                if (ph == H_LAST) capture = 1'b1;
                if (ph == P_LAST) begin
                    ph_nxt = '0;
                    if (bit_cnt == BIT_LAST) begin
                        state_nxt = ST_QUIET;
                        done      = 1'b1;
                    end else begin
                        bit_nxt = bit_cnt + 4'd1;
                    end
                end
            end
            default: begin
                if (ph == H_LAST) begin
                    state_nxt = ST_IDLE;
                    ph_nxt    = '0;
                end
            end
        endcase
    end

    // Pin levels come from next-state so every output is a flop.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state            <= ST_IDLE;
            ph               <= '0;
            bit_cnt          <= '0;
            shift_q          <= '0;
            adc.cs_n         <= 1'b1;
            adc.sclk         <= 1'b1;
            adc.busy         <= 1'b0;
            adc.overrun      <= 1'b0;
            adc.sample       <= '0;
            adc.sample_valid <= 1'b0;
        end else begin
            state            <= state_nxt;
            ph               <= ph_nxt;
            bit_cnt          <= bit_nxt;
            adc.cs_n         <= !(state_nxt == ST_SETUP || state_nxt == ST_SHIFT);
            adc.sclk         <= !(state_nxt == ST_SHIFT && ph_nxt < H_COUNT);
            adc.busy         <= (state_nxt != ST_IDLE);
            adc.overrun      <= tick && (state != ST_IDLE);
            adc.sample_valid <= done;
            // Leading zeros simply fall off the top of the 12-bit register.
            if (capture) shift_q <= {shift_q[SHIFT_W-2:0], adc.sdata};
            if (done) adc.sample <= DATA_W'(to_signed_code(shift_q)) << (DATA_W - ADC_BITS);
        end
    end
endmodule

// File: tb/tb_adc_spi_capture.sv
// tb/tb_adc_spi_capture.sv - directed bench for adc_spi_capture with a behavioural AD7476 model
module tb_adc_spi_capture;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic en = 1'b0;
    logic en_ov = 1'b0;
    logic [15:0] adc_word = 16'h0000;
    logic [15:0] adc_word_ov = 16'h0000;
    int cyc = 0;
    int rises = 0;
    int consec = 0;
    int ov_main = 0;
    int n_run = 0;
    int n_fail = 0;
    int bidx, bidx_ov;
    logic prev_v = 1'b0;

    adc_spi_capture_if #(.DATA_W(24)) m ();
    adc_spi_capture_if #(.DATA_W(24)) o ();

    adc_spi_capture #(.DATA_W(24), .SCLK_HALF(2), .SAMPLE_PERIOD(100)) dut (
        .clk(clk), .reset(reset), .en(en), .adc(m)
    );

    // Period deliberately shorter than a frame so a request lands while busy.
    adc_spi_capture #(.DATA_W(24), .SCLK_HALF(2), .SAMPLE_PERIOD(40)) dut_ov (
        .clk(clk), .reset(reset), .en(en_ov), .adc(o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;
    always @(posedge m.sclk) if (m.cs_n === 1'b0) rises++;

    always @(negedge clk) begin
        if (m.sample_valid === 1'b1 && prev_v === 1'b1) consec++;
        prev_v = m.sample_valid;
        if (m.overrun === 1'b1) ov_main++;
    end

    initial m.sdata = 1'b0;
    always begin
        @(negedge m.cs_n);
        bidx = 15;
        m.sdata = adc_word[bidx];
        while (m.cs_n === 1'b0) begin
            @(posedge m.sclk or posedge m.cs_n);
            #1;
            if (bidx > 0) bidx--;
            m.sdata = adc_word[bidx];
        end
    end

    initial o.sdata = 1'b0;
    always begin
        @(negedge o.cs_n);
        bidx_ov = 15;
        o.sdata = adc_word_ov[bidx_ov];
        while (o.cs_n === 1'b0) begin
            @(posedge o.sclk or posedge o.cs_n);
            #1;
            if (bidx_ov > 0) bidx_ov--;
            o.sdata = adc_word_ov[bidx_ov];
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_run++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic frame(input logic [15:0] w, input logic [31:0] exp, input int drop_at,
                         input string tag, output int vcyc);
        int n, lows, vin;
        adc_word = w;
        rises = 0;
        n = 0;
        while (m.cs_n !== 1'b0 && n < 400) begin @(negedge clk); n++; end
        check({tag, "_start"}, 32'(n < 400), 32'd1);
        lows = 0;
        vin = 0;
        while (m.cs_n === 1'b0 && lows < 200) begin
            if (m.sample_valid === 1'b1) vin++;
            if (lows == drop_at) en = 1'b0;
            @(negedge clk);
            lows++;
        end
        vcyc = cyc;
        check({tag, "_cs_low_cycles"}, 32'(lows), 32'd66);
        check({tag, "_sclk_rises"}, 32'(rises), 32'd16);
        check({tag, "_early_valid"}, 32'(vin), 32'd0);
        check({tag, "_valid"}, 32'(m.sample_valid), 32'd1);
        check({tag, "_sample"}, 32'(m.sample), exp);
        check({tag, "_busy_quiet"}, 32'(m.busy), 32'd1);
        @(negedge clk);
        check({tag, "_valid_off"}, 32'(m.sample_valid), 32'd0);
        check({tag, "_sample_hold"}, 32'(m.sample), exp);
    endtask

    initial begin
        int v0, v1, v2, v3, v4, n, lows, cnt, vcnt, ovc, ov_idx, vin;
        en = 1'b1;
        repeat (5) @(negedge clk);
        check("rst_cs_n", 32'(m.cs_n), 32'd1);
        check("rst_sclk", 32'(m.sclk), 32'd1);
        check("rst_sample", 32'(m.sample), 32'd0);
        check("rst_valid", 32'(m.sample_valid), 32'd0);
        check("rst_busy", 32'(m.busy), 32'd0);
        check("rst_overrun", 32'(m.overrun), 32'd0);
        reset = 1'b0;

        frame(16'h0800, 32'h000000, -1, "mid", v0);
        frame(16'h0FFF, 32'h7FF000, -1, "max", v1);
        check("period_max", 32'(v1 - v0), 32'd100);
        frame(16'h0000, 32'h800000, -1, "min", v2);
        check("period_min", 32'(v2 - v1), 32'd100);
        frame(16'hF123, 32'h923000, -1, "lead", v3);
        check("period_lead", 32'(v3 - v2), 32'd100);

        // Reset landing in bit 7 of the shift phase.
        adc_word = 16'h0FFF;
        n = 0;
        while (m.cs_n !== 1'b0 && n < 400) begin @(negedge clk); n++; end
        check("rstmid_start", 32'(n < 400), 32'd1);
        repeat (30) @(negedge clk);
        reset = 1'b1;
        #1;
        check("rstmid_cs_n", 32'(m.cs_n), 32'd1);
        check("rstmid_sclk", 32'(m.sclk), 32'd1);
        check("rstmid_busy", 32'(m.busy), 32'd0);
        check("rstmid_sample", 32'(m.sample), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        vcnt = 0;
        repeat (60) begin
            @(negedge clk);
            if (m.sample_valid === 1'b1) vcnt++;
        end
        check("rstmid_no_valid", 32'(vcnt), 32'd0);
        check("rstmid_sample_zero", 32'(m.sample), 32'd0);

        // en dropped during bit 7: frame still completes, then silence.
        frame(16'h0ABC, 32'h2BC000, 30, "endrop", v4);
        cnt = 0;
        vcnt = 0;
        repeat (300) begin
            @(negedge clk);
            if (m.cs_n !== 1'b1) cnt++;
            if (m.sample_valid === 1'b1) vcnt++;
        end
        check("endrop_cs_idle", 32'(cnt), 32'd0);
        check("endrop_no_valid", 32'(vcnt), 32'd0);
        check("endrop_sample_hold", 32'(m.sample), 32'h2BC000);

        // Overrun: second request arrives 40 cycles into a 68-cycle busy window.
        adc_word_ov = 16'h0456;
        en_ov = 1'b1;
        n = 0;
        while (o.cs_n !== 1'b0 && n < 200) begin @(negedge clk); n++; end
        check("ovr_start", 32'(n < 200), 32'd1);
        lows = 0;
        ovc = 0;
        ov_idx = -1;
        vin = 0;
        while (o.cs_n === 1'b0 && lows < 200) begin
            if (o.overrun === 1'b1) begin ovc++; ov_idx = lows; end
            if (o.sample_valid === 1'b1) vin++;
            @(negedge clk);
            lows++;
        end
        check("ovr_cs_low_cycles", 32'(lows), 32'd66);
        check("ovr_pulses", 32'(ovc), 32'd1);
        check("ovr_pulse_pos", 32'(ov_idx), 32'd40);
        check("ovr_early_valid", 32'(vin), 32'd0);
        check("ovr_valid", 32'(o.sample_valid), 32'd1);
        check("ovr_sample", 32'(o.sample), 32'hC56000);
        n = 0;
        while (o.cs_n !== 1'b0 && n < 200) begin @(negedge clk); n++; end
        check("ovr_next_frame_gap", 32'(n), 32'd14);
        en_ov = 1'b0;

        check("valid_never_double", 32'(consec), 32'd0);
        check("main_no_overrun", 32'(ov_main), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end
endmodule
